regwrite_decoder: RTL and testbench
===================================

REGWRITE_DECODER -- requirements
Module: regwrite_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning the data bits per register.
REQ-002 SHALL have parameter NREGS, default 32, meaning the register count; the address width SHALL be 5 bits, so NREGS is fixed at 32.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port wr_valid, input, 1 bit: a write request is presented.
REQ-006 SHALL have port wr_ready, output, 1 bit: the block can accept a write request.
REQ-007 SHALL have port wr_addr, input, 5 bits: destination register index.
REQ-008 SHALL have port wr_data, input, WIDTH bits: write data.
REQ-009 SHALL have port clear_req, input, 1 bit: request to zero all registers sequentially.
REQ-010 SHALL have port we_onehot, output, 32 bits: the registered decoded write enable of the pending stage.
REQ-011 SHALL have port wr_done, output, 1 bit: one-cycle pulse after a commit.
REQ-012 SHALL have port busy, output, 1 bit: the clear sweep is in progress.
REQ-013 SHALL have port regs, output, [31:0][WIDTH-1:0]: the packed register array, indexable by the existing 32:1 read mux.

Function
REQ-014 SHALL implement the FSM states IDLE and CLEAR, with wr_ready = (state==IDLE) and busy = (state==CLEAR).
REQ-015 SHALL accept a write at an edge where wr_valid && wr_ready, capturing wr_data and a one-hot decode of wr_addr into the stage register (we_onehot).
REQ-016 SHALL commit the stage to regs[idx] at the next edge (one-cycle latency) and clear we_onehot to 0 unless a new write is accepted at that edge.
REQ-017 SHALL assert wr_done for exactly the one cycle following each commit.
REQ-018 SHALL sustain back-to-back writes at 1 per cycle while in IDLE, with no bubble.
REQ-019 SHALL move from IDLE to CLEAR when clear_req is sampled high in IDLE, with clr_cnt=0.
REQ-020 SHALL, in CLEAR, zero regs[clr_cnt] each edge and increment clr_cnt; after zeroing index 31 it SHALL return to IDLE, so CLEAR lasts exactly 32 cycles.
REQ-021 SHALL ignore clear_req while in CLEAR (no restart, no extension).
REQ-022 SHALL, when a write is accepted on the same edge as clear_req, enter CLEAR and still commit the write on the next edge.
REQ-023 SHALL give the clear priority when a commit and a clear target the same index on the same edge, leaving that register at 0.
REQ-024 SHALL leave regs unchanged at an edge with no commit and no clear.

Reset
REQ-025 SHALL, while reset is high, asynchronously force state=IDLE, clr_cnt=0, all regs=0, we_onehot=0, wr_done=0, busy=0 and wr_ready=1.
REQ-026 SHALL, when reset is asserted mid-CLEAR or with a pending stage, discard the pending write and abort the sweep.

Configuration
REQ-027 SHALL, with macro REGWRITE_ZERO_REG_EN defined, hold regs[31] constant at 0 (XZR), treat writes to address 31 as accepted but not committed (wr_done still pulses, regs[31] unchanged), and set we_onehot bit 31 to 0.
REQ-028 SHALL, without REGWRITE_ZERO_REG_EN, treat register 31 like any other register.

Verification
REQ-029 SHALL pass this scenario: reset, then write 155+i to address i for i=0..31 back-to-back -> wr_ready stays 1, each regs[i]=155+i one cycle after acceptance, 32 wr_done pulses.
REQ-030 SHALL pass this scenario: write addr=5, data=64'hDEAD_BEEF -> the next cycle we_onehot=32'h0000_0020; the following edge regs[5]=64'hDEAD_BEEF and wr_done=1 for one cycle.
REQ-031 SHALL pass this scenario: fill all registers, pulse clear_req -> busy=1 and wr_ready=0 for exactly 32 cycles, then all regs=0 and wr_ready=1.
REQ-032 SHALL pass this scenario: write addr=0, data=7 on the same edge as clear_req -> regs[0]=0 after the sweep (clear priority); repeated with addr=31 -> regs[31]=0.
REQ-033 SHALL pass this scenario: assert reset at cycle 10 of a CLEAR with a pending write to addr 3 -> immediately all regs=0, state IDLE, no wr_done.
REQ-034 SHALL pass this scenario: with REGWRITE_ZERO_REG_EN defined, write addr=31, data=64'd343 -> regs[31] stays 0 and wr_done pulses; without the macro -> regs[31]=343.

Source files
------------

// File: rtl/regwrite_decoder.sv
// regwrite_decoder
//   Register-file write path. A write is captured into a one-entry stage
//   (data plus a one-hot decode of the address) and committed to the
//   register array on the following edge. A clear request starts a
//   32-cycle sweep that zeroes one register per cycle; new writes are
//   refused while the sweep runs.
//
//   Optional feature (macro REGWRITE_ZERO_REG_EN): register 31 is a
//   hard-wired zero register. Writes to it are accepted and signal
//   wr_done, but never change it, and we_onehot bit 31 stays 0.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high reset
//   wr_valid   : write request present
//   wr_ready   : write can be accepted (high in IDLE)
//   wr_addr    : destination register index
//   wr_data    : write data
//   clear_req  : start a sequential clear of all registers
//   we_onehot  : registered one-hot write enable of the pending stage
//   wr_done    : one-cycle pulse after each commit
//   busy       : clear sweep in progress
//   regs       : packed register array
module regwrite_decoder #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned NREGS = 32
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              wr_valid,
   output logic                              wr_ready,
   input  logic [4:0]                        wr_addr,
   input  logic [WIDTH-1:0]                  wr_data,
   input  logic                              clear_req,
   output logic [NREGS-1:0]                  we_onehot,
   output logic                              wr_done,
   output logic                              busy,
   output logic [NREGS-1:0][WIDTH-1:0]       regs
);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t                          state_q, state_d;
   logic [4:0]                      clr_cnt_q, clr_cnt_d;
   logic [NREGS-1:0]                we_onehot_q, we_onehot_d;
   logic [WIDTH-1:0]                stage_data_q, stage_data_d;
   logic                            stage_vld_q, stage_vld_d;
   logic                            wr_done_q, wr_done_d;
   logic [NREGS-1:0][WIDTH-1:0]     regs_q, regs_d;

   logic                            accept;
   logic [NREGS-1:0]                addr_onehot;

   assign wr_ready  = (state_q == IDLE);
   assign busy      = (state_q == CLEAR);
   assign we_onehot = we_onehot_q;
   assign wr_done   = wr_done_q;
   assign regs      = regs_q;

   assign accept = wr_valid && wr_ready;

   always_comb begin
      addr_onehot          = '0;
      addr_onehot[wr_addr] = 1'b1;
`ifdef REGWRITE_ZERO_REG_EN
      addr_onehot[NREGS-1] = 1'b0;
`endif
   end

   // State and sweep counter
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d   = CLEAR;
               clr_cnt_d = '0;
            end
         end
         CLEAR: begin
            clr_cnt_d = clr_cnt_q + 5'd1;
            if (clr_cnt_q == 5'd31) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d   = IDLE;
            clr_cnt_d = '0;
         end
      endcase
   end

   // Stage capture. stage_vld tracks acceptance separately from the
   // one-hot so a masked zero-register write still produces wr_done.
   always_comb begin
      we_onehot_d  = accept ? addr_onehot : '0;
      stage_data_d = accept ? wr_data : stage_data_q;
      stage_vld_d  = accept;
      wr_done_d    = stage_vld_q;
   end

   // Commit, then sweep: the sweep is applied last so it wins on a
   // same-index collision.
   always_comb begin
      regs_d = regs_q;
      for (int unsigned i = 0; i < NREGS; i++) begin
         if (we_onehot_q[i]) begin
            regs_d[i] = stage_data_q;
         end
         if ((state_q == CLEAR) && (clr_cnt_q == 5'(i))) begin
            regs_d[i] = '0;
         end
      end
`ifdef REGWRITE_ZERO_REG_EN
      regs_d[NREGS-1] = '0;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         clr_cnt_q    <= '0;
         we_onehot_q  <= '0;
         stage_data_q <= '0;
         stage_vld_q  <= 1'b0;
         wr_done_q    <= 1'b0;
         regs_q       <= '0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         we_onehot_q  <= we_onehot_d;
         stage_data_q <= stage_data_d;
         stage_vld_q  <= stage_vld_d;
         wr_done_q    <= wr_done_d;
         regs_q       <= regs_d;
      end
   end

endmodule

// File: tb/tb_regwrite_decoder.sv
// Testbench for regwrite_decoder: directed scenarios followed by random
// traffic, compared every cycle against a behavioural model.
module tb_regwrite_decoder;

`ifdef REGWRITE_ZERO_REG_EN
   localparam bit ZR = 1'b1;
`else
   localparam bit ZR = 1'b0;
`endif

   logic                 clk;
   logic                 reset;
   logic                 wr_valid;
   logic                 wr_ready;
   logic [4:0]           wr_addr;
   logic [63:0]          wr_data;
   logic                 clear_req;
   logic [31:0]          we_onehot;
   logic                 wr_done;
   logic                 busy;
   logic [31:0][63:0]    regs;

   regwrite_decoder #(
      .WIDTH (64),
      .NREGS (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .clear_req (clear_req),
      .we_onehot (we_onehot),
      .wr_done   (wr_done),
      .busy      (busy),
      .regs      (regs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp;
   int unsigned n_bad;

   // Behavioural model
   logic [31:0][63:0] m_regs;
   int                m_clr_left;
   int                m_clr_idx;
   bit                m_pend;
   int                m_pa;
   logic [63:0]       m_pd;
   bit                m_done;

   task automatic model_reset();
      m_regs     = '0;
      m_clr_left = 0;
      m_clr_idx  = 0;
      m_pend     = 1'b0;
      m_pa       = 0;
      m_pd       = '0;
      m_done     = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs now applied.
   task automatic model_step();
      bit ready;
      bit acc;
      ready = (m_clr_left == 0);
      acc   = wr_valid && ready;
      if (m_pend && !(ZR && m_pa == 31)) m_regs[m_pa] = m_pd;
      m_done = m_pend;
      if (m_clr_left > 0) begin
         m_regs[m_clr_idx] = '0;
         m_clr_idx++;
         m_clr_left--;
      end else if (clear_req) begin
         m_clr_left = 32;
         m_clr_idx  = 0;
      end
      m_pend = acc;
      if (acc) begin
         m_pa = int'(wr_addr);
         m_pd = wr_data;
      end
   endtask

   function automatic logic [31:0] m_onehot();
      logic [31:0] v;
      v = '0;
      if (m_pend && !(ZR && m_pa == 31)) v[m_pa] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_regs(input string tag, input logic [31:0][63:0] exp);
      int idx;
      idx = 0;
      for (int i = 31; i >= 0; i--) if (regs[i] !== exp[i]) idx = i;
      n_cmp++;
      assert (regs === exp) else begin
         n_bad++;
         $error("FAIL %s: regs[%0d] observed %0h expected %0h", tag, idx, regs[idx], exp[idx]);
      end
   endtask

   task automatic check_all();
      chk("wr_ready", 64'(wr_ready), 64'(m_clr_left == 0));
      chk("busy", 64'(busy), 64'(m_clr_left != 0));
      chk("we_onehot", 64'(we_onehot), 64'(m_onehot()));
      chk("wr_done", 64'(wr_done), 64'(m_done));
      chk_regs("regs", m_regs);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle_in();
      wr_valid  = 1'b0;
      clear_req = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
   endtask

   // Assert reset between edges and check its immediate effect.
   task automatic async_reset(input string tag);
      reset = 1'b1;
      #2;
      chk({tag, "_ready"}, 64'(wr_ready), 64'd1);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_onehot"}, 64'(we_onehot), 64'd0);
      chk({tag, "_done"}, 64'(wr_done), 64'd0);
      chk_regs({tag, "_regs"}, '0);
      model_reset();
      #1;
      reset = 1'b0;
   endtask

   int unsigned cnt;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      idle_in();
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 64'(wr_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_onehot", 64'(we_onehot), 64'd0);
      chk("rst_done", 64'(wr_done), 64'd0);
      chk_regs("rst_regs", '0);
      #3;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Back-to-back fill: 155+i to address i
      cnt = 0;
      for (int i = 0; i < 32; i++) begin
         wr_valid = 1'b1;
         wr_addr  = 5'(i);
         wr_data  = 64'(155 + i);
         tick();
         if (wr_done) cnt++;
      end
      idle_in();
      repeat (2) begin
         tick();
         if (wr_done) cnt++;
      end
      chk("fill_done_count", 64'(cnt), 64'd32);
      chk("fill_reg7", regs[7], 64'd162);
      chk("fill_reg31", regs[31], ZR ? 64'd0 : 64'd186);

      // Single write, latency check
      wr_valid = 1'b1;
      wr_addr  = 5'd5;
      wr_data  = 64'hDEAD_BEEF;
      tick();
      idle_in();
      chk("w5_onehot", 64'(we_onehot), 64'h20);
      tick();
      chk("w5_reg", regs[5], 64'hDEAD_BEEF);
      chk("w5_done", 64'(wr_done), 64'd1);
      tick();
      chk("w5_done_clr", 64'(wr_done), 64'd0);

      // Clear sweep over a full array
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      cnt = (busy && !wr_ready) ? 1 : 0;
      for (int i = 0; i < 33; i++) begin
         clear_req = (i == 4);    // must be ignored mid-sweep
         tick();
         if (busy && !wr_ready) cnt++;
      end
      idle_in();
      chk("clr_busy_cycles", 64'(cnt), 64'd32);
      chk_regs("clr_all_zero", '0);

      // Write colliding with clear: addr 0 then addr 31
      for (int k = 0; k < 2; k++) begin
         wr_valid  = 1'b1;
         wr_addr   = (k == 0) ? 5'd0 : 5'd31;
         wr_data   = 64'd7;
         clear_req = 1'b1;
         tick();
         idle_in();
         repeat (33) tick();
         chk(k == 0 ? "coll_reg0" : "coll_reg31", regs[k == 0 ? 0 : 31], 64'd0);
         chk(k == 0 ? "coll_ready0" : "coll_ready31", 64'(wr_ready), 64'd1);
      end

      // Reset with a pending write to addr 3
      wr_valid = 1'b1;
      wr_addr  = 5'd3;
      wr_data  = 64'h33;
      tick();
      idle_in();
      async_reset("rst_pend");
      tick();
      chk("rst_pend_no_done", 64'(wr_done), 64'd0);
      chk("rst_pend_reg3", regs[3], 64'd0);

      // Reset at cycle 10 of a sweep started together with a write to addr 3
      for (int i = 0; i < 8; i++) begin
         wr_valid = 1'b1;
         wr_addr  = 5'(20 + i);
         wr_data  = 64'(1000 + i);
         tick();
      end
      wr_addr   = 5'd3;
      wr_data   = 64'h3333;
      clear_req = 1'b1;
      tick();
      idle_in();
      repeat (10) tick();
      async_reset("rst_clr");
      tick();
      chk("rst_clr_idle", 64'(wr_ready), 64'd1);
      chk("rst_clr_no_done", 64'(wr_done), 64'd0);

      // Zero-register behaviour
      wr_valid = 1'b1;
      wr_addr  = 5'd31;
      wr_data  = 64'd343;
      tick();
      idle_in();
      chk("zr_onehot", 64'(we_onehot), ZR ? 64'd0 : 64'h8000_0000);
      tick();
      chk("zr_done", 64'(wr_done), 64'd1);
      chk("zr_reg31", regs[31], ZR ? 64'd0 : 64'd343);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         wr_valid  = ($urandom_range(0, 3) != 0);
         wr_addr   = 5'($urandom_range(0, 31));
         wr_data   = {$urandom, $urandom};
         clear_req = ($urandom_range(0, 40) == 0);
         tick();
      end
      idle_in();
      repeat (35) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
